// File: rtl/led_serial_receiver.sv
// Serial-to-parallel receiver for the three-wire LED link (SCLK, SData, SLatch_n).
// Rebuilds WIDTH-bit words, checks frame length and strobes o_Valid or o_FrameErr.
module led_serial_receiver #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int BYTE_SWAP   = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET_n,
  input  logic             i_SCLK,
  input  logic             i_SData,
  input  logic             i_SLatch_n,
  output logic [WIDTH-1:0] o_Data16,
  output logic             o_Valid,
  output logic             o_FrameErr,
  output logic             o_Busy
);

  // state   | meaning
  // IDLE    | no bits held, count = 0
  // SHIFT   | 1..WIDTH bits held
  // OVERRUN | more than WIDTH bits seen, further bits discarded
  typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

  localparam int CW = $clog2(WIDTH + 2);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_OVR   = CW'(WIDTH + 1);
  localparam logic [CW-1:0] SWAP_MASK = (BYTE_SWAP != 0) ? CW'(8) : '0;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic                   r_sclk_prev;
  logic                   r_latch_prev;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;

  logic             w_sclk_rise;
  logic             w_latch_fall;
  logic             w_sdata;
  logic [CW-1:0]    w_pos;
  state_t           w_state_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_shift_nxt;

  // Flops preset to link idle levels so reset release never looks like an edge
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      r_sclk_sync  <= '0;
      r_sdata_sync <= '0;
      r_latch_sync <= '1;
      r_sclk_prev  <= 1'b0;
      r_latch_prev <= 1'b1;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], i_SCLK};
      r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], i_SData};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], i_SLatch_n};
      r_sclk_prev  <= r_sclk_sync[SYNC_STAGES-1];
      r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
    end
  end

  assign w_sclk_rise  = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign w_latch_fall = ~r_latch_sync[SYNC_STAGES-1] & r_latch_prev;
  assign w_sdata      = r_sdata_sync[SYNC_STAGES-1];
  assign w_pos        = r_count ^ SWAP_MASK;

  // Shift happens before the frame check so a bit and latch in one cycle count
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    if (w_sclk_rise) begin
      case (r_state)
        IDLE, SHIFT: begin
          if (r_count == CNT_FULL) begin
            w_state_nxt = OVERRUN;
            w_count_nxt = CNT_OVR;
          end else begin
            if (w_pos < CNT_FULL) w_shift_nxt[w_pos[IW-1:0]] = w_sdata;
            w_count_nxt = r_count + CW'(1);
            w_state_nxt = SHIFT;
          end
        end
        default: begin
          w_state_nxt = OVERRUN;
          w_count_nxt = CNT_OVR;
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_shift    <= '0;
      o_Data16   <= '0;
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      o_Valid    <= 1'b0;
      o_FrameErr <= 1'b0;
      if (w_latch_fall) begin
        if (w_state_nxt == SHIFT && w_count_nxt == CNT_FULL) begin
          o_Data16 <= w_shift_nxt;
          o_Valid  <= 1'b1;
        end else begin
          o_FrameErr <= 1'b1;
        end
        r_state <= IDLE;
        r_count <= '0;
        r_shift <= '0;
        o_Busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_count <= w_count_nxt;
        r_shift <= w_shift_nxt;
        o_Busy  <= (w_state_nxt != IDLE);
      end
    end
  end

endmodule

// File: tb/tb_led_serial_receiver.sv
// Directed bench for led_serial_receiver: drives the link and checks words, strobes and latency.
module tb_led_serial_receiver;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        sclk, sdata, slatch_n;
  logic [15:0] data16;
  logic        valid, frame_err, busy;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic [15:0] valid_q[$];

  always #5 clk_sys = ~clk_sys;

  led_serial_receiver #(.WIDTH(16), .SYNC_STAGES(2), .BYTE_SWAP(1)) dut (
    .i_CLK      (clk_sys),
    .i_RESET_n  (rst_n),
    .i_SCLK     (sclk),
    .i_SData    (sdata),
    .i_SLatch_n (slatch_n),
    .o_Data16   (data16),
    .o_Valid    (valid),
    .o_FrameErr (frame_err),
    .o_Busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (rst_n && (valid || frame_err)) begin
      chk("strobe_excl", {31'd0, valid & frame_err}, 32'd0);
      if (valid) begin
        valid_cnt++;
        valid_q.push_back(data16);
      end
      if (frame_err) err_cnt++;
    end
  end

  // lmode: 0 no latch, 1 latch after last bit, 2 latch on last SCLK rise
  task automatic send_word(input logic [15:0] w, input int nbits, input int lmode, input int ph);
    logic v1, v2, v3;
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk_sys);
      sclk  = 1'b0;
      sdata = w[(k ^ 8) & 15];
      repeat (ph) @(negedge clk_sys);
      sclk = 1'b1;
      if (k == nbits - 1 && lmode == 2) begin
        slatch_n = 1'b0;
        @(posedge clk_sys); #1 v1 = valid;
        @(posedge clk_sys); #1 v2 = valid;
        @(posedge clk_sys); #1 v3 = valid;
        if (nbits == 16) begin
          chk("lat_e1", {31'd0, v1}, 32'd0);
          chk("lat_e2", {31'd0, v2}, 32'd0);
          chk("lat_e3", {31'd0, v3}, 32'd1);
          chk("busy_gap", {31'd0, busy}, 32'd0);
        end
        @(negedge clk_sys);
        sclk = 1'b0;
        slatch_n = 1'b1;
      end else begin
        repeat (ph) @(negedge clk_sys);
        sclk = 1'b0;
      end
    end
    if (lmode == 1) begin
      repeat (3) @(negedge clk_sys);
      slatch_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      slatch_n = 1'b1;
    end
  endtask

  task automatic settle();
    repeat (6) @(negedge clk_sys);
  endtask

  int v0, e0;

  initial begin
    rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; slatch_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_data", {16'd0, data16}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    settle();
    chk("rel_no_strobe", valid_cnt + err_cnt, 32'd0);

    // Good frame with latch on last edge
    send_word(16'hA53C, 16, 2, 3);
    settle();
    chk("a53c_valid", valid_cnt, 32'd1);
    chk("a53c_data", {16'd0, data16}, 32'h0000A53C);
    chk("a53c_err", err_cnt, 32'd0);

    // Back-to-back stream
    valid_q.delete();
    send_word(16'h1234, 16, 2, 3);
    send_word(16'hFFFF, 16, 2, 3);
    send_word(16'h0001, 16, 2, 3);
    settle();
    chk("b2b_count", valid_q.size(), 32'd3);
    if (valid_q.size() == 3) begin
      chk("b2b_w0", {16'd0, valid_q[0]}, 32'h00001234);
      chk("b2b_w1", {16'd0, valid_q[1]}, 32'h0000FFFF);
      chk("b2b_w2", {16'd0, valid_q[2]}, 32'h00000001);
    end
    chk("b2b_err", err_cnt, 32'd0);

    // Restore 0xA53C as the held word, then short frame
    send_word(16'hA53C, 16, 1, 3);
    settle();
    chk("sep_latch_data", {16'd0, data16}, 32'h0000A53C);
    v0 = valid_cnt; e0 = err_cnt;
    send_word(16'h5555, 15, 1, 3);
    settle();
    chk("short_err", err_cnt - e0, 32'd1);
    chk("short_valid", valid_cnt - v0, 32'd0);
    chk("short_hold", {16'd0, data16}, 32'h0000A53C);

    // Overrun frame
    v0 = valid_cnt; e0 = err_cnt;
    send_word(16'h0F0F, 17, 1, 3);
    settle();
    chk("over_err", err_cnt - e0, 32'd1);
    chk("over_valid", valid_cnt - v0, 32'd0);
    chk("over_idle", {31'd0, busy}, 32'd0);
    chk("over_hold", {16'd0, data16}, 32'h0000A53C);

    // Latch with no bits
    e0 = err_cnt;
    send_word(16'h0000, 0, 1, 3);
    settle();
    chk("idle_latch_err", err_cnt - e0, 32'd1);

    // Recovery after overrun, latch on last edge (also re-checks latency)
    send_word(16'hC3A5, 16, 2, 3);
    settle();
    chk("recover_data", {16'd0, data16}, 32'h0000C3A5);

    // Reset mid-frame
    send_word(16'hBEEF, 8, 0, 3);
    settle();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {16'd0, data16}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    settle();
    chk("mid_rst_nopulse", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
    send_word(16'h00FF, 16, 1, 3);
    settle();
    chk("post_rst_valid", valid_cnt - v0, 32'd1);
    chk("post_rst_data", {16'd0, data16}, 32'h000000FF);

    // Fast link: never a wrong word
    v0 = valid_cnt; e0 = err_cnt;
    send_word(16'h9A6B, 16, 1, 1);
    settle();
    chk("fast_safe", {31'd0, ((valid_cnt - v0 == 1) && (err_cnt == e0) && (data16 == 16'h9A6B)) ||
                              ((err_cnt - e0 == 1) && (valid_cnt == v0) && (data16 == 16'h00FF))},
        32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/led_serial_receiver.md
# led_serial_receiver

Serial-to-parallel receiver for the three-wire LED shift-register link (serial clock, serial data, active-low latch). It reconstructs each 16-bit word from the serial stream, checks the frame length, and presents the word with a one-cycle valid strobe. It sits on the far end of the LED link: on-board loopback monitoring, link self-test, or a second board consuming the display stream. All link inputs are asynchronous to i_CLK and are synchronized internally.

## Interface
- WIDTH, 16, word length in bits; frame is valid only when exactly WIDTH bits precede the latch.
- SYNC_STAGES, 2, flip-flop stages per link input synchronizer (≥2).
- BYTE_SWAP, 1, 1: received bit k lands at o_Data16[k ^ 8]; 0: lands at o_Data16[k].
- i_CLK  in  1  system clock, all logic on rising edge.
- i_RESET_n  in  1  asynchronous, active-low reset.
- i_SCLK  in  1  link serial clock; data sampled on its rising edge.
- i_SData  in  1  link serial data.
- i_SLatch_n  in  1  link latch, active low; falling edge closes a frame.
- o_Data16  out  WIDTH  last good word, held until next good frame.
- o_Valid  out  1  one-cycle pulse when o_Data16 updates.
- o_FrameErr  out  1  one-cycle pulse when a frame is rejected.
- o_Busy  out  1  high while a frame is partially received (bit count ≠ 0).

## Operation
- Reset (async, i_RESET_n low): o_Data16=0, o_Valid=0, o_FrameErr=0, o_Busy=0, bit count=0, shift register=0, state IDLE. Synchronizer and edge-history flops preset to link idle levels (SCLK=0, SData=0, Latch_n=1), so no false edge on reset release.
- Edge detect on synchronized signals: SCLK rise = sync out 1, previous 0; latch fall = sync out 0, previous 1.
- States: IDLE (count 0), SHIFT (1..WIDTH bits held), OVERRUN (>WIDTH bits seen).
- SCLK rise: capture synchronized SData into position k = count (with BYTE_SWAP mapping); count++. IDLE→SHIFT on first bit; SHIFT→OVERRUN when a bit arrives with count = WIDTH. In OVERRUN bits are discarded, count saturates.
- Latch fall: if count = WIDTH and state SHIFT, o_Data16 ← shift register, o_Valid pulse; otherwise (short frame, overrun, or latch in IDLE) o_FrameErr pulse, o_Data16 unchanged. In all cases count←0, shift register←0, state→IDLE.
- Simultaneous SCLK rise and latch fall in one cycle: bit is shifted and counted first, then frame check uses the updated count (the transmitter asserts latch on the same edge that clocks the last bit). A 16th bit plus latch in the same cycle therefore yields a good frame.
- o_Valid and o_FrameErr never both high. o_Busy = (state ≠ IDLE).
- Count width: clog2(WIDTH+2) bits; no wrap.

## Timing
- Input-to-detect: pin edge sampled at i_CLK edge 1, visible after SYNC_STAGES edges; o_Data16/o_Valid/o_FrameErr registered one edge later: latency SYNC_STAGES+1 i_CLK edges from first sampling edge of latch fall.
- Link constraint: each SCLK high and low phase and each latch low pulse ≥ SYNC_STAGES i_CLK periods; SData stable ≥ SYNC_STAGES+1 periods around SCLK rise. Faster links are out of spec (edges may be lost; lost edges show as frame errors).
- Back-to-back frames: next bit may arrive the cycle after latch fall is detected.
- Reset mid-frame: partial frame discarded, no pulse, o_Data16 cleared to 0.

## Test plan
- 16 bits of 0xA53C (transmitter order, BYTE_SWAP=1: bits 8..15 then 0..7), latch on last SCLK edge -> single o_Valid pulse, o_Data16=0xA53C, o_FrameErr stays 0.
- Continuous stream 0x1234, 0xFFFF, 0x0001 back-to-back -> three o_Valid pulses in order with those values, o_Busy low only between latch and next bit.
- 15 bits then latch -> o_FrameErr pulse, o_Data16 retains previous 0xA53C; 17 bits then latch -> o_FrameErr, state IDLE afterwards.
- Latch fall and 16th SCLK rise in same i_CLK cycle -> good frame, o_Valid at SYNC_STAGES+1 edges later.
- i_RESET_n pulsed low after 8 bits -> outputs 0 immediately; following full 16-bit frame 0x00FF -> o_Valid, o_Data16=0x00FF.
- SCLK phases of 1 i_CLK period (out of spec) -> no o_Valid with wrong data: either correct word or o_FrameErr.
